// File: rtl/bcd_serial_subtractor_if.sv
// Operand/result bundle for bcd_serial_subtractor; digit 0 sits in bits [3:0],
// MSD at the top of each 4*NDIGITS-bit field.
interface bcd_serial_subtractor_if #(
  parameter int NDIGITS = 4
);
  logic                   start;
  logic [4*NDIGITS-1:0]   a_bcd;
  logic [4*NDIGITS-1:0]   b_bcd;
  logic                   busy;
  logic                   done;
  logic [4*NDIGITS-1:0]   diff_bcd;
  logic                   neg;
  logic                   invalid;

  modport master (
    output start, a_bcd, b_bcd,
    input  busy, done, diff_bcd, neg, invalid
  );

  modport slave (
    input  start, a_bcd, b_bcd,
    output busy, done, diff_bcd, neg, invalid
  );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD magnitude subtractor: NDIGITS compare cycles (MSD first), then
// NDIGITS subtract cycles (LSD first). Define BCD_SUB_INPUT_CHECK_EN to reject non-BCD operands.
module bcd_serial_subtractor #(
  parameter int NDIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  bcd_serial_subtractor_if.slave   bus
);

  localparam int         W    = 4 * NDIGITS;
  localparam logic [3:0] LAST = 4'(NDIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    SUB,
    DONE
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_diff;
  logic [3:0]     r_cnt;
  logic           r_found;
  logic           r_swap;
  logic           r_borrow;
  logic           r_neg;
  logic           r_busy;
  logic           r_done;

  logic [3:0]     w_cmp_idx;
  logic [3:0]     w_ca;
  logic [3:0]     w_cb;
  logic [3:0]     w_x;
  logic [3:0]     w_y;
  logic [4:0]     w_yb;
  logic [3:0]     w_digit;
  logic           w_borrow;
  logic [W-1:0]   w_acc_next;

`ifdef BCD_SUB_INPUT_CHECK_EN
  logic           r_invalid;

  function automatic logic has_non_bcd(input logic [W-1:0] v);
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction
`endif

  // Compare reads the MSD-first digit pair; subtract works on the LSD-first pair,
  // with r_swap selecting which operand is the larger one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_digit    = 4'd0;
    w_borrow   = 1'b0;
    w_cmp_idx  = LAST - r_cnt;
    w_ca       = r_a[4*w_cmp_idx +: 4];
    w_cb       = r_b[4*w_cmp_idx +: 4];
    w_x        = r_swap ? r_b[4*r_cnt +: 4] : r_a[4*r_cnt +: 4];
    w_y        = r_swap ? r_a[4*r_cnt +: 4] : r_b[4*r_cnt +: 4];
    w_yb       = {1'b0, w_y} + {4'b0, r_borrow};
    if ({1'b0, w_x} < w_yb) begin
      w_digit  = 4'({1'b0, w_x} + 5'd10 - w_yb);
      w_borrow = 1'b1;
    end else begin
      w_digit  = 4'({1'b0, w_x} - w_yb);
      w_borrow = 1'b0;
    end
    w_acc_next = r_acc;
    w_acc_next[4*r_cnt +: 4] = w_digit;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_found  <= 1'b0;
      r_swap   <= 1'b0;
      r_borrow <= 1'b0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef BCD_SUB_INPUT_CHECK_EN
      r_invalid <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a_bcd;
            r_b      <= bus.b_bcd;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_found  <= 1'b0;
            r_swap   <= 1'b0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b1;
`ifdef BCD_SUB_INPUT_CHECK_EN
            if (has_non_bcd(bus.a_bcd) || has_non_bcd(bus.b_bcd)) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_diff    <= '0;
              r_neg     <= 1'b0;
              r_invalid <= 1'b1;
            end else begin
              r_state   <= CMP;
            end
`else
            r_state  <= CMP;
`endif
          end
        end

        CMP: begin
          // Fixed latency: keep scanning after the first difference, but only it decides order.
          if (!r_found && (w_ca != w_cb)) begin
            r_found <= 1'b1;
            r_swap  <= (w_ca < w_cb);
          end
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= SUB;
          end else begin
            r_cnt   <= r_cnt + 4'd1;
          end
        end

        SUB: begin
          r_acc    <= w_acc_next;
          r_borrow <= w_borrow;
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= DONE;
            r_done  <= 1'b1;
            r_diff  <= w_acc_next;
            r_neg   <= r_swap;
`ifdef BCD_SUB_INPUT_CHECK_EN
            r_invalid <= 1'b0;
`endif
          end else begin
            r_cnt   <= r_cnt + 4'd1;
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.diff_bcd = r_diff;
  assign bus.neg      = r_neg;
`ifdef BCD_SUB_INPUT_CHECK_EN
  assign bus.invalid  = r_invalid;
`else
  assign bus.invalid  = 1'b0;
`endif

endmodule
